// File: rtl/rtr_systolic_mcast.sv
// ============================================================================
// Module   : rtr_systolic_mcast
// Brief    : Per-PE systolic router with DEPTH-stage iact forwarding, runtime
//            systolic/broadcast/multicast/isolate delivery and a psum skid buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rtr_systolic_mcast #(
    parameter int I_WIDTH    = 8,
    parameter int P_WIDTH    = 20,
    parameter int CTRL_WIDTH = 1,
    parameter int ID_WIDTH   = 4,
    parameter int DEPTH      = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_we,
    input  logic [1:0]            cfg_mode,
    input  logic [ID_WIDTH-1:0]   cfg_id,
    output logic                  cfg_busy,
    output logic                  cfg_err,
    input  logic [CTRL_WIDTH-1:0] global_ctrl_in,
    input  logic [I_WIDTH-1:0]    global_iact_in,
    input  logic                  global_iact_valid_in,
    input  logic [ID_WIDTH-1:0]   global_iact_tag_in,
    output logic [CTRL_WIDTH-1:0] global_ctrl_out,
    output logic [I_WIDTH-1:0]    global_iact_out,
    output logic                  global_iact_valid_out,
    output logic [ID_WIDTH-1:0]   global_iact_tag_out,
    output logic [CTRL_WIDTH-1:0] local_ctrl_out,
    output logic [I_WIDTH-1:0]    local_iact_out,
    output logic                  local_iact_valid,
    input  logic [P_WIDTH-1:0]    global_psum_in,
    input  logic                  global_psum_valid_in,
    output logic                  global_psum_ready_out,
    output logic [P_WIDTH-1:0]    local_psum_out,
    output logic                  local_psum_valid_out,
    input  logic                  local_psum_ready_in,
    input  logic [P_WIDTH-1:0]    local_psum_in,
    input  logic                  local_psum_valid_in,
    output logic                  local_psum_ready_out,
    output logic [P_WIDTH-1:0]    global_psum_out,
    output logic                  global_psum_valid_out,
    input  logic                  global_psum_ready_in
);

    localparam logic [1:0] c_MODE_SYS = 2'b00;
    localparam logic [1:0] c_MODE_BC  = 2'b01;
    localparam logic [1:0] c_MODE_MC  = 2'b10;
    localparam logic [1:0] c_MODE_ISO = 2'b11;

    logic [1:0]          r_mode;
    logic [ID_WIDTH-1:0] r_id;
    logic                r_err;

    // ------------------------------------------------------------------
    // Forwarding delay line
    // ------------------------------------------------------------------
    logic [I_WIDTH-1:0]    r_dly_iact  [DEPTH];
    logic [CTRL_WIDTH-1:0] r_dly_ctrl  [DEPTH];
    logic [ID_WIDTH-1:0]   r_dly_tag   [DEPTH];
    logic                  r_dly_valid [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dly_iact[0]  <= '0;
            r_dly_ctrl[0]  <= '0;
            r_dly_tag[0]   <= '0;
            r_dly_valid[0] <= 1'b0;
        end else begin
            r_dly_iact[0]  <= global_iact_in;
            r_dly_ctrl[0]  <= global_ctrl_in;
            r_dly_tag[0]   <= global_iact_tag_in;
            r_dly_valid[0] <= global_iact_valid_in;
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi < DEPTH; gi++) begin : g_dly
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_dly_iact[gi]  <= '0;
                    r_dly_ctrl[gi]  <= '0;
                    r_dly_tag[gi]   <= '0;
                    r_dly_valid[gi] <= 1'b0;
                end else begin
                    r_dly_iact[gi]  <= r_dly_iact[gi-1];
                    r_dly_ctrl[gi]  <= r_dly_ctrl[gi-1];
                    r_dly_tag[gi]   <= r_dly_tag[gi-1];
                    r_dly_valid[gi] <= r_dly_valid[gi-1];
                end
            end
        end
    endgenerate

    assign global_iact_out       = r_dly_iact[DEPTH-1];
    assign global_ctrl_out       = r_dly_ctrl[DEPTH-1];
    assign global_iact_tag_out   = r_dly_tag[DEPTH-1];
    assign global_iact_valid_out = r_dly_valid[DEPTH-1];

    // ------------------------------------------------------------------
    // Local iact delivery
    // ------------------------------------------------------------------
    logic w_tag_hit;
    logic w_local_valid;

    assign w_tag_hit = (global_iact_tag_in == r_id) || (&global_iact_tag_in);

    always_comb begin
        w_local_valid = 1'b0;
        case (r_mode)
            c_MODE_SYS, c_MODE_BC: w_local_valid = global_iact_valid_in;
            c_MODE_MC:             w_local_valid = global_iact_valid_in & w_tag_hit;
            default:               w_local_valid = 1'b0;
        endcase
    end

    assign local_iact_out   = global_iact_in;
    assign local_ctrl_out   = global_ctrl_in;
    assign local_iact_valid = w_local_valid;

    // ------------------------------------------------------------------
    // Psum routing and 2-entry skid buffer
    // ------------------------------------------------------------------
    logic               w_iso;
    logic [P_WIDTH-1:0] w_src_data;
    logic               w_src_valid;
    logic               w_src_ready;
    logic               w_push;
    logic               w_pop;
    logic               w_cfg_accept;

    logic [P_WIDTH-1:0] r_buf [2];
    logic               r_wr_ptr;
    logic               r_rd_ptr;
    logic [1:0]         r_count;

    assign w_iso       = (r_mode == c_MODE_ISO);
    assign w_src_data  = w_iso ? global_psum_in : local_psum_in;
    assign w_src_valid = w_iso ? global_psum_valid_in : local_psum_valid_in;
    // A pop only frees the slot on the following cycle, so full means not ready.
    assign w_src_ready = (r_count != 2'd2);
    assign w_push      = w_src_valid & w_src_ready;
    assign w_pop       = (r_count != 2'd0) & global_psum_ready_in;

    assign local_psum_out        = global_psum_in;
    assign local_psum_valid_out  = ~w_iso & global_psum_valid_in;
    assign global_psum_ready_out = w_iso ? w_src_ready : local_psum_ready_in;
    assign local_psum_ready_out  = ~w_iso & w_src_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf[0] <= '0;
            r_buf[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_buf[r_wr_ptr] <= w_src_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign global_psum_out       = r_buf[r_rd_ptr];
    assign global_psum_valid_out = (r_count != 2'd0);

    // ------------------------------------------------------------------
    // Configuration: only taken while the psum path is quiescent
    // ------------------------------------------------------------------
    assign w_cfg_accept = cfg_we & (r_count == 2'd0) & ~w_push;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= c_MODE_SYS;
            r_id   <= '0;
            r_err  <= 1'b0;
        end else begin
            r_err <= cfg_we & ~w_cfg_accept;
            if (w_cfg_accept) begin
                r_mode <= cfg_mode;
                r_id   <= cfg_id;
            end
        end
    end

    assign cfg_busy = (r_count != 2'd0);
    assign cfg_err  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_rtr_systolic_mcast.sv
// ============================================================================
// Module   : tb_rtr_systolic_mcast
// Brief    : Scoreboard bench for rtr_systolic_mcast (DEPTH=3).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rtr_systolic_mcast;

    localparam int c_DEPTH = 3;

    logic        clk;
    logic        rst_n;
    logic        cfg_we;
    logic [1:0]  cfg_mode;
    logic [3:0]  cfg_id;
    logic        cfg_busy;
    logic        cfg_err;
    logic [0:0]  global_ctrl_in;
    logic [7:0]  global_iact_in;
    logic        global_iact_valid_in;
    logic [3:0]  global_iact_tag_in;
    logic [0:0]  global_ctrl_out;
    logic [7:0]  global_iact_out;
    logic        global_iact_valid_out;
    logic [3:0]  global_iact_tag_out;
    logic [0:0]  local_ctrl_out;
    logic [7:0]  local_iact_out;
    logic        local_iact_valid;
    logic [19:0] global_psum_in;
    logic        global_psum_valid_in;
    logic        global_psum_ready_out;
    logic [19:0] local_psum_out;
    logic        local_psum_valid_out;
    logic        local_psum_ready_in;
    logic [19:0] local_psum_in;
    logic        local_psum_valid_in;
    logic        local_psum_ready_out;
    logic [19:0] global_psum_out;
    logic        global_psum_valid_out;
    logic        global_psum_ready_in;

    rtr_systolic_mcast #(.DEPTH(c_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_mode(cfg_mode), .cfg_id(cfg_id),
        .cfg_busy(cfg_busy), .cfg_err(cfg_err),
        .global_ctrl_in(global_ctrl_in), .global_iact_in(global_iact_in),
        .global_iact_valid_in(global_iact_valid_in), .global_iact_tag_in(global_iact_tag_in),
        .global_ctrl_out(global_ctrl_out), .global_iact_out(global_iact_out),
        .global_iact_valid_out(global_iact_valid_out), .global_iact_tag_out(global_iact_tag_out),
        .local_ctrl_out(local_ctrl_out), .local_iact_out(local_iact_out),
        .local_iact_valid(local_iact_valid),
        .global_psum_in(global_psum_in), .global_psum_valid_in(global_psum_valid_in),
        .global_psum_ready_out(global_psum_ready_out),
        .local_psum_out(local_psum_out), .local_psum_valid_out(local_psum_valid_out),
        .local_psum_ready_in(local_psum_ready_in),
        .local_psum_in(local_psum_in), .local_psum_valid_in(local_psum_valid_in),
        .local_psum_ready_out(local_psum_ready_out),
        .global_psum_out(global_psum_out), .global_psum_valid_out(global_psum_valid_out),
        .global_psum_ready_in(global_psum_ready_in)
    );

    typedef struct {
        logic [7:0] iact;
        logic [3:0] tag;
        logic       ctrl;
        int         cyc;
    } fwd_t;

    fwd_t        fwd_q[$];
    logic [19:0] psum_q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one iact beat; local delivery is checked right away, forwarding via the monitor
    task automatic iact(input logic [7:0] d, input logic [3:0] t, input logic c,
                        input logic exp_lv, input string name);
        fwd_t e;
        global_iact_in       = d;
        global_iact_tag_in   = t;
        global_ctrl_in       = c;
        global_iact_valid_in = 1'b1;
        e.iact = d; e.tag = t; e.ctrl = c; e.cyc = cyc + c_DEPTH;
        fwd_q.push_back(e);
        #1;
        chk(name, {31'd0, local_iact_valid}, {31'd0, exp_lv});
        chk({name, "_data"}, {24'd0, local_iact_out}, {24'd0, d});
        chk({name, "_ctrl"}, {31'd0, local_ctrl_out}, {31'd0, c});
    endtask

    task automatic cfg(input logic [1:0] m, input logic [3:0] id, input logic exp_err);
        step();
        cfg_we   = 1'b1;
        cfg_mode = m;
        cfg_id   = id;
        step();
        cfg_we = 1'b0;
        chk("cfg_err", {31'd0, cfg_err}, {31'd0, exp_err});
        step();
        chk("cfg_err_pulse_end", {31'd0, cfg_err}, 32'd0);
    endtask

    task automatic drain();
        for (int k = 0; k < 40; k++) begin
            if (!cfg_busy) break;
            step();
        end
        chk("drain_busy", {31'd0, cfg_busy}, 32'd0);
    endtask

    // Psum monitor: every downstream handshake must match the next expected psum
    always @(negedge clk) begin
        if (rst_n && global_psum_valid_out && global_psum_ready_in) begin
            if (psum_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL psum_unexpected: got %0h expected none", global_psum_out);
            end else begin
                chk("psum_out", {12'd0, global_psum_out}, {12'd0, psum_q.pop_front()});
            end
        end
    end

    // Forward monitor: each beat must appear exactly DEPTH cycles after it was driven
    always @(negedge clk) begin
        fwd_t e;
        if (global_iact_valid_out) begin
            if (fwd_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL fwd_unexpected: got %0h expected none", global_iact_out);
            end else begin
                e = fwd_q.pop_front();
                chk("fwd_iact", {24'd0, global_iact_out}, {24'd0, e.iact});
                chk("fwd_tag",  {28'd0, global_iact_tag_out}, {28'd0, e.tag});
                chk("fwd_ctrl", {31'd0, global_ctrl_out}, {31'd0, e.ctrl});
                chk("fwd_cycle", cyc, e.cyc);
            end
        end else if (fwd_q.size() > 0 && fwd_q[0].cyc <= cyc) begin
            e = fwd_q.pop_front();
            tests++; fails++;
            $display("FAIL fwd_missing: got no valid expected %0h at cycle %0d", e.iact, e.cyc);
        end
    end

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_mode = 2'b00; cfg_id = 4'd0;
        global_ctrl_in = 1'b0; global_iact_in = 8'd0; global_iact_valid_in = 1'b0;
        global_iact_tag_in = 4'd0; global_psum_in = 20'd0; global_psum_valid_in = 1'b0;
        local_psum_ready_in = 1'b0; local_psum_in = 20'd0; local_psum_valid_in = 1'b0;
        global_psum_ready_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        chk("rst_fwd_valid",  {31'd0, global_iact_valid_out}, 32'd0);
        chk("rst_psum_valid", {31'd0, global_psum_valid_out}, 32'd0);
        chk("rst_busy",       {31'd0, cfg_busy}, 32'd0);
        chk("rst_err",        {31'd0, cfg_err}, 32'd0);
        chk("rst_lpsum_rdy",  {31'd0, local_psum_ready_out}, 32'd1);

        // SYSTOLIC forwarding
        step(); iact(8'h11, 4'h0, 1'b0, 1'b1, "sys_lv0");
        step(); iact(8'h22, 4'h0, 1'b1, 1'b1, "sys_lv1");
        step(); iact(8'h33, 4'h0, 1'b0, 1'b1, "sys_lv2");
        step(); global_iact_valid_in = 1'b0;

        // SYSTOLIC psum passthrough
        global_psum_in = 20'h00055; global_psum_valid_in = 1'b1; local_psum_ready_in = 1'b1;
        #1;
        chk("pass_data",  {12'd0, local_psum_out}, 32'h55);
        chk("pass_valid", {31'd0, local_psum_valid_out}, 32'd1);
        chk("pass_ready", {31'd0, global_psum_ready_out}, 32'd1);
        local_psum_ready_in = 1'b0;
        #1 chk("pass_ready_lo", {31'd0, global_psum_ready_out}, 32'd0);
        global_psum_valid_in = 1'b0;

        // MULTICAST id=5
        cfg(2'b10, 4'h5, 1'b0);
        step(); iact(8'hA0, 4'h5, 1'b0, 1'b1, "mc_hit");
        step(); iact(8'hA1, 4'h3, 1'b1, 1'b0, "mc_miss");
        step(); iact(8'hA2, 4'hF, 1'b0, 1'b1, "mc_all");
        step(); global_iact_valid_in = 1'b0;

        // Psum backpressure in SYSTOLIC
        cfg(2'b00, 4'h0, 1'b0);
        global_psum_ready_in = 1'b0;
        step(); local_psum_in = 20'h00010; local_psum_valid_in = 1'b1;
        #1 chk("bp_rdy_1", {31'd0, local_psum_ready_out}, 32'd1); psum_q.push_back(20'h00010);
        step(); local_psum_in = 20'h00020;
        #1 chk("bp_rdy_2", {31'd0, local_psum_ready_out}, 32'd1); psum_q.push_back(20'h00020);
        step(); local_psum_in = 20'h00030;
        #1 chk("bp_full_rdy", {31'd0, local_psum_ready_out}, 32'd0);
        chk("bp_busy", {31'd0, cfg_busy}, 32'd1);
        step(); global_psum_ready_in = 1'b1;
        #1 chk("bp_rdy_pop_cycle", {31'd0, local_psum_ready_out}, 32'd0);
        step();
        chk("bp_rdy_after_pop", {31'd0, local_psum_ready_out}, 32'd1); psum_q.push_back(20'h00030);
        step(); local_psum_valid_in = 1'b0;
        drain();

        // Config rejected while buffer holds one entry
        global_psum_ready_in = 1'b0;
        step(); local_psum_in = 20'h00040; local_psum_valid_in = 1'b1;
        #1 chk("rej_push_rdy", {31'd0, local_psum_ready_out}, 32'd1); psum_q.push_back(20'h00040);
        step(); local_psum_valid_in = 1'b0;
        cfg(2'b10, 4'h7, 1'b1);
        step(); iact(8'hB3, 4'h3, 1'b0, 1'b1, "rej_mode_kept");
        step(); global_iact_valid_in = 1'b0; global_psum_ready_in = 1'b1;
        drain();
        cfg(2'b10, 4'h7, 1'b0);
        step(); iact(8'hC3, 4'h3, 1'b0, 1'b0, "acc_mc_miss");
        step(); iact(8'hC7, 4'h7, 1'b1, 1'b1, "acc_mc_hit");
        step(); global_iact_valid_in = 1'b0;

        // ISOLATE
        cfg(2'b11, 4'h0, 1'b0);
        step();
        global_psum_in = 20'h12345; global_psum_valid_in = 1'b1; local_psum_ready_in = 1'b1;
        iact(8'h77, 4'h2, 1'b0, 1'b0, "iso_lv");
        chk("iso_lpsum_valid", {31'd0, local_psum_valid_out}, 32'd0);
        chk("iso_gpsum_rdy",   {31'd0, global_psum_ready_out}, 32'd1);
        chk("iso_lpsum_rdy",   {31'd0, local_psum_ready_out}, 32'd0);
        psum_q.push_back(20'h12345);
        step(); global_psum_valid_in = 1'b0; global_iact_valid_in = 1'b0;
        chk("iso_out_valid", {31'd0, global_psum_valid_out}, 32'd1);
        chk("iso_out_data",  {12'd0, global_psum_out}, 32'h12345);
        step();

        // Reset mid-operation with buffered psums and iact in flight
        global_psum_ready_in = 1'b0;
        step(); global_psum_in = 20'h0AAAA; global_psum_valid_in = 1'b1;
        step(); global_psum_in = 20'h0BBBB;
        step(); global_psum_valid_in = 1'b0;
        global_iact_in = 8'h99; global_iact_valid_in = 1'b1;
        step(); global_iact_valid_in = 1'b0;
        chk("mid_busy", {31'd0, cfg_busy}, 32'd1);
        #1 rst_n = 1'b0;
        fwd_q.delete(); psum_q.delete();
        #1;
        chk("mid_rst_psum_valid", {31'd0, global_psum_valid_out}, 32'd0);
        chk("mid_rst_busy",       {31'd0, cfg_busy}, 32'd0);
        step(); step();
        rst_n = 1'b1; global_psum_ready_in = 1'b1;
        repeat (6) step();
        chk("post_fwd_valid",  {31'd0, global_iact_valid_out}, 32'd0);
        chk("post_psum_valid", {31'd0, global_psum_valid_out}, 32'd0);
        iact(8'hD1, 4'h3, 1'b1, 1'b1, "post_mode_sys");
        step(); global_iact_valid_in = 1'b0;

        repeat (6) step();
        chk("fwd_q_left",  fwd_q.size(), 32'd0);
        chk("psum_q_left", psum_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
